// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequences the PWM core's d/sel bus to program the period,
// restart the counter and ramp the compare value from a start duty to an end
// duty. Compare updates are issued only on the cycle where the core counter
// wraps, so the new duty covers a whole period.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for start; bus holds
// LOAD_TOP | write latched period value into the core top register
// LOAD_CNT | restart the core counter at 0
// LOAD_CMP | write the start duty into the core compare register
// RUN      | count periods at each wrap; write the next duty every pps_eff periods
// DONE     | ramp finished; one-cycle done pulse
module pwm_ramp_ctrl #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] cfg_top,
    input  logic [W-1:0] cfg_duty_start,
    input  logic [W-1:0] cfg_duty_end,
    input  logic [W-1:0] cfg_step,
    input  logic [W-1:0] cfg_pps,
    input  logic [W-1:0] pwm_cnt,
    input  logic [W-1:0] pwm_top,
    output logic [W-1:0] pwm_d,
    output logic [1:0]   pwm_sel,
    output logic         busy,
    output logic         done
);

    localparam logic [1:0]   SEL_HOLD = 2'b00;
    localparam logic [1:0]   SEL_CMP  = 2'b01;
    localparam logic [1:0]   SEL_TOP  = 2'b10;
    localparam logic [1:0]   SEL_CNT  = 2'b11;
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_TOP = 3'd1,
        LOAD_CNT = 3'd2,
        LOAD_CMP = 3'd3,
        RUN      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t       state;
    logic [W-1:0] top_r;
    logic [W-1:0] duty_start_r;
    logic [W-1:0] duty_end_r;
    logic [W-1:0] step_r;
    logic [W-1:0] pps_r;
    logic [W-1:0] cur;
    logic [W-1:0] per;
    logic         up_r;

    logic [W-1:0] step_eff;
    logic [W-1:0] pps_eff;
    logic [W:0]   sum;
    logic [W-1:0] diff;
    logic [W-1:0] next_duty;
    logic         boundary;
    logic         upd;

    // Next duty value with saturation at the end duty in either direction.
    always_comb begin
        step_eff  = (step_r == '0) ? ONE : step_r;
        pps_eff   = (pps_r == '0) ? ONE : pps_r;
        sum       = {1'b0, cur} + {1'b0, step_eff};
        diff      = cur - step_eff;
        next_duty = duty_end_r;
        if (up_r) begin
            if (sum < {1'b0, duty_end_r}) begin
                next_duty = sum[W-1:0];
            end
        end else begin
            if (!(cur < step_eff) && (diff > duty_end_r)) begin
                next_duty = diff;
            end
        end
        boundary  = (pwm_cnt >= pwm_top);
        upd       = (state == RUN) && boundary && (per == pps_eff - ONE);
    end

    // Sequencer state and latched ramp configuration; abort overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            top_r        <= '0;
            duty_start_r <= '0;
            duty_end_r   <= '0;
            step_r       <= '0;
            pps_r        <= '0;
            cur          <= '0;
            per          <= '0;
            up_r         <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        top_r        <= cfg_top;
                        duty_start_r <= cfg_duty_start;
                        duty_end_r   <= cfg_duty_end;
                        step_r       <= cfg_step;
                        pps_r        <= cfg_pps;
                        cur          <= cfg_duty_start;
                        per          <= '0;
                        up_r         <= (cfg_duty_end > cfg_duty_start);
                        state        <= LOAD_TOP;
                    end
                end
                LOAD_TOP: state <= LOAD_CNT;
                LOAD_CNT: state <= LOAD_CMP;
                LOAD_CMP: state <= (duty_start_r == duty_end_r) ? DONE : RUN;
                RUN: begin
                    if (upd) begin
                        cur <= next_duty;
                        per <= '0;
                        if (next_duty == duty_end_r) begin
                            state <= DONE;
                        end
                    end else if (boundary) begin
                        per <= per + ONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Core bus decode; the RUN write is qualified by the live wrap compare.
    always_comb begin
        pwm_sel = SEL_HOLD;
        pwm_d   = '0;
        case (state)
            LOAD_TOP: begin
                pwm_sel = SEL_TOP;
                pwm_d   = top_r;
            end
            LOAD_CNT: begin
                pwm_sel = SEL_CNT;
                pwm_d   = '0;
            end
            LOAD_CMP: begin
                pwm_sel = SEL_CMP;
                pwm_d   = duty_start_r;
            end
            RUN: begin
                if (upd) begin
                    pwm_sel = SEL_CMP;
                    pwm_d   = next_duty;
                end
            end
            default: begin
                pwm_sel = SEL_HOLD;
                pwm_d   = '0;
            end
        endcase
    end

    // Status flags decoded from the state register only.
    always_comb begin
        busy = (state == LOAD_TOP) || (state == LOAD_CNT) ||
               (state == LOAD_CMP) || (state == RUN);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with a small behavioural PWM core model.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_top = '0;
    logic [15:0] cfg_duty_start = '0;
    logic [15:0] cfg_duty_end = '0;
    logic [15:0] cfg_step = '0;
    logic [15:0] cfg_pps = '0;
    logic [15:0] pwm_cnt;
    logic [15:0] pwm_top;
    logic [15:0] pwm_d;
    logic [1:0]  pwm_sel;
    logic        busy;
    logic        done;

    logic [15:0] core_top = '0;
    logic [15:0] core_cnt = '0;
    logic [15:0] core_cmp = '0;

    logic [1:0]  sel_log  [0:63];
    logic [15:0] d_log    [0:63];
    logic        busy_log [0:63];
    logic        done_log [0:63];
    int          n_wr;
    int          n_done;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(.W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .cfg_top        (cfg_top),
        .cfg_duty_start (cfg_duty_start),
        .cfg_duty_end   (cfg_duty_end),
        .cfg_step       (cfg_step),
        .cfg_pps        (cfg_pps),
        .pwm_cnt        (pwm_cnt),
        .pwm_top        (pwm_top),
        .pwm_d          (pwm_d),
        .pwm_sel        (pwm_sel),
        .busy           (busy),
        .done           (done)
    );

    assign pwm_cnt = core_cnt;
    assign pwm_top = core_top;

    // PWM core model: counter wraps after top, counts unless being written.
    always @(posedge clk) begin
        case (pwm_sel)
            2'b10: begin
                core_top <= pwm_d;
                core_cnt <= (core_cnt >= core_top) ? 16'd0 : core_cnt + 16'd1;
            end
            2'b11: core_cnt <= pwm_d;
            default: begin
                if (pwm_sel == 2'b01) core_cmp <= pwm_d;
                core_cnt <= (core_cnt >= core_top) ? 16'd0 : core_cnt + 16'd1;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Pulses start for edge E0 and logs cycles 1..ncyc.
    task automatic run_seq(input logic [15:0] t, input logic [15:0] ds, input logic [15:0] de,
                           input logic [15:0] st, input logic [15:0] pp, input int ncyc,
                           input int abort_cyc, input int dist_cyc);
        cfg_top        = t;
        cfg_duty_start = ds;
        cfg_duty_end   = de;
        cfg_step       = st;
        cfg_pps        = pp;
        start          = 1'b1;
        abort          = (abort_cyc == 0);
        n_wr           = 0;
        n_done         = 0;
        for (int c = 0; c < 64; c++) begin
            sel_log[c]  = 2'b00;
            d_log[c]    = '0;
            busy_log[c] = 1'b0;
            done_log[c] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            sel_log[c]  = pwm_sel;
            d_log[c]    = pwm_d;
            busy_log[c] = busy;
            done_log[c] = done;
            if (pwm_sel != 2'b00) n_wr++;
            if (done) n_done++;
            abort = (c == abort_cyc);
            start = (c == dist_cyc);
            if (c == dist_cyc) begin
                cfg_top        = 16'd2;
                cfg_duty_start = 16'd7;
                cfg_duty_end   = 16'd1;
                cfg_step       = 16'd3;
                cfg_pps        = 16'd5;
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(pwm_sel), 32'd0);
        chk("rst_d", 32'(pwm_d), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Up ramp, with a start/cfg disturbance while busy.
        run_seq(16'd9, 16'd2, 16'd6, 16'd2, 16'd1, 25, -1, 5);
        chk("up_c1_sel", 32'(sel_log[1]), 32'd2);
        chk("up_c1_d", 32'(d_log[1]), 32'd9);
        chk("up_c2_sel", 32'(sel_log[2]), 32'd3);
        chk("up_c2_d", 32'(d_log[2]), 32'd0);
        chk("up_c3_sel", 32'(sel_log[3]), 32'd1);
        chk("up_c3_d", 32'(d_log[3]), 32'd2);
        chk("up_c11_sel", 32'(sel_log[11]), 32'd0);
        chk("up_c12_sel", 32'(sel_log[12]), 32'd1);
        chk("up_c12_d", 32'(d_log[12]), 32'd4);
        chk("up_c22_sel", 32'(sel_log[22]), 32'd1);
        chk("up_c22_d", 32'(d_log[22]), 32'd6);
        chk("up_nwr", 32'(n_wr), 32'd5);
        chk("up_busy22", 32'(busy_log[22]), 32'd1);
        chk("up_busy23", 32'(busy_log[23]), 32'd0);
        chk("up_done23", 32'(done_log[23]), 32'd1);
        chk("up_ndone", 32'(n_done), 32'd1);
        chk("up_core_cmp", 32'(core_cmp), 32'd6);

        // Down ramp with saturation, two periods per step.
        run_seq(16'd4, 16'd10, 16'd1, 16'd4, 16'd2, 36, -1, -1);
        chk("dn_c3_d", 32'(d_log[3]), 32'd10);
        chk("dn_c7_sel", 32'(sel_log[7]), 32'd0);
        chk("dn_c12_d", 32'(d_log[12]), 32'd6);
        chk("dn_c22_d", 32'(d_log[22]), 32'd2);
        chk("dn_c32_sel", 32'(sel_log[32]), 32'd1);
        chk("dn_c32_d", 32'(d_log[32]), 32'd1);
        chk("dn_nwr", 32'(n_wr), 32'd6);
        chk("dn_done33", 32'(done_log[33]), 32'd1);
        chk("dn_ndone", 32'(n_done), 32'd1);

        // Degenerate: start equals end.
        run_seq(16'd9, 16'd5, 16'd5, 16'd1, 16'd1, 6, -1, -1);
        chk("eq_c3_d", 32'(d_log[3]), 32'd5);
        chk("eq_nwr", 32'(n_wr), 32'd3);
        chk("eq_done4", 32'(done_log[4]), 32'd1);
        chk("eq_busy4", 32'(busy_log[4]), 32'd0);

        // step=0 and pps=0 behave as 1.
        run_seq(16'd3, 16'd0, 16'd3, 16'd0, 16'd0, 17, -1, -1);
        chk("z_c6_d", 32'(d_log[6]), 32'd1);
        chk("z_c10_d", 32'(d_log[10]), 32'd2);
        chk("z_c14_d", 32'(d_log[14]), 32'd3);
        chk("z_nwr", 32'(n_wr), 32'd6);
        chk("z_done15", 32'(done_log[15]), 32'd1);

        // Overflow guard near full scale.
        run_seq(16'd3, 16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 9, -1, -1);
        chk("ov_c3_d", 32'(d_log[3]), 32'hFFF0);
        chk("ov_c6_d", 32'(d_log[6]), 32'hFFFF);
        chk("ov_nwr", 32'(n_wr), 32'd4);
        chk("ov_done7", 32'(done_log[7]), 32'd1);

        // Abort mid-period in RUN.
        run_seq(16'd9, 16'd2, 16'd6, 16'd2, 16'd1, 16, 15, -1);
        chk("ab_c12_d", 32'(d_log[12]), 32'd4);
        chk("ab_busy15", 32'(busy_log[15]), 32'd1);
        chk("ab_busy16", 32'(busy_log[16]), 32'd0);
        chk("ab_sel16", 32'(sel_log[16]), 32'd0);
        chk("ab_ndone", 32'(n_done), 32'd0);
        chk("ab_core_cmp", 32'(core_cmp), 32'd4);

        // Restart accepted in the cycle right after the abort.
        run_seq(16'd5, 16'd1, 16'd3, 16'd1, 16'd1, 8, 7, -1);
        chk("rs_c1_sel", 32'(sel_log[1]), 32'd2);
        chk("rs_c1_d", 32'(d_log[1]), 32'd5);
        chk("rs_busy8", 32'(busy_log[8]), 32'd0);
        chk("rs_ndone", 32'(n_done), 32'd0);

        // start together with abort in IDLE stays IDLE.
        run_seq(16'd9, 16'd2, 16'd6, 16'd2, 16'd1, 4, 0, -1);
        chk("sa_nwr", 32'(n_wr), 32'd0);
        chk("sa_busy1", 32'(busy_log[1]), 32'd0);

        // Asynchronous reset during an update-boundary cycle.
        run_seq(16'd9, 16'd2, 16'd6, 16'd2, 16'd1, 12, -1, -1);
        chk("ar_pre_sel", 32'(sel_log[12]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(pwm_sel), 32'd0);
        chk("ar_d", 32'(pwm_d), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_after_busy", 32'(busy), 32'd0);
        chk("ar_after_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
